// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the parametrised UART FIFO.
// The optional error-sticky feature is enabled by defining UART_FIFO_ERR_EN.
package uart_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_BITS  = 4;

   localparam int POLICY_DROP      = 0;
   localparam int POLICY_OVERWRITE = 1;

   typedef enum logic [1:0] {
      LVL_HOLD = 2'd0,
      LVL_INC  = 2'd1,
      LVL_DEC  = 2'd2
   } level_op_e;

   // Occupancy spans 0..DEPTH inclusive, so it needs one bit more than an address.
   function automatic int level_width(input int addr_bits);
      return addr_bits + 1;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the UART FIFO: one write port, one registered read port.
// No reset on the array or the read register; locations are always written before being read.
module uart_fifo_mem
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
   input  logic                  clock,
   input  logic                  wr_en_i,
   input  logic [ADDR_BITS-1:0]  wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_BITS-1:0]  rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Read-before-write: a simultaneous read of the slot being overwritten sees the old word.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_fifo_buffer.sv
// Parametrised UART FIFO with drop/overwrite policy, level, thresholds and registered read port.
// Define UART_FIFO_ERR_EN to add overflow_sticky/underflow_sticky outputs and err_clear input.
module uart_fifo_buffer
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_BITS  = DEF_ADDR_BITS,
   parameter int AF_LEVEL   = (2 ** ADDR_BITS) - 2,
   parameter int AE_LEVEL   = 2,
   parameter int OVERWRITE  = POLICY_DROP
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              wr_en,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic                              rd_en,
   output logic [DATA_WIDTH-1:0]             rd_data,
   output logic                              rd_valid,
   output logic [level_width(ADDR_BITS)-1:0] level,
   output logic                              full,
   output logic                              empty,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic                              overflow,
   output logic                              underflow
`ifdef UART_FIFO_ERR_EN
   ,
   input  logic                              err_clear,
   output logic                              overflow_sticky,
   output logic                              underflow_sticky
`endif
);

   localparam int             LW       = level_width(ADDR_BITS);
   localparam int             DEPTH    = 2 ** ADDR_BITS;
   localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0]  LVL_AF   = LW'(AF_LEVEL);
   localparam logic [LW-1:0]  LVL_AE   = LW'(AE_LEVEL);
   localparam logic           OVW_EN   = (OVERWRITE == POLICY_OVERWRITE);

   logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  primed_q, primed_d;
   logic                  rd_acc, wr_acc, ovw_evict;
   level_op_e             lvl_op;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   assign full         = (level_q == LVL_FULL);
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q <= LVL_AE);

   always_comb begin
      rd_acc      = rd_en && !empty;
      wr_acc      = wr_en && (!full || rd_acc || OVW_EN);
      // Overwrite-when-full evicts the oldest word so the level stays at DEPTH.
      ovw_evict   = wr_en && full && !rd_acc && OVW_EN;
      overflow_d  = wr_en && full && !rd_acc;
      underflow_d = rd_en && empty;
      rd_valid_d  = rd_acc;
      primed_d    = primed_q || rd_acc;

      lvl_op = LVL_HOLD;
      if (wr_acc && !rd_acc && !ovw_evict) begin
         lvl_op = LVL_INC;
      end else if (rd_acc && !wr_acc) begin
         lvl_op = LVL_DEC;
      end

      wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
      rd_ptr_d = (rd_acc || ovw_evict) ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;

      case (lvl_op)
         LVL_INC: level_d = level_q + LW'(1);
         LVL_DEC: level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         primed_q    <= primed_d;
      end
   end

   uart_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (mem_rd_data)
   );

   // The storage read register has no reset, so rd_data reads as zero until the first pop.
   assign rd_data   = primed_q ? mem_rd_data : '0;
   assign rd_valid  = rd_valid_q;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`ifdef UART_FIFO_ERR_EN
   logic ovf_sticky_q, ovf_sticky_d;
   logic udf_sticky_q, udf_sticky_d;

   // Stickies rise together with their pulse; a coincident clear loses to the set.
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      udf_sticky_d = udf_sticky_q;
      if (overflow_d) begin
         ovf_sticky_d = 1'b1;
      end else if (err_clear) begin
         ovf_sticky_d = 1'b0;
      end
      if (underflow_d) begin
         udf_sticky_d = 1'b1;
      end else if (err_clear) begin
         udf_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
         udf_sticky_q <= udf_sticky_d;
      end
   end

   assign overflow_sticky  = ovf_sticky_q;
   assign underflow_sticky = udf_sticky_q;
`endif

endmodule

// File: tb/tb_uart_fifo_buffer.sv
// Self-checking bench: drop-policy and overwrite-policy FIFOs share stimulus and are
// compared each cycle against queue-based models; UART_FIFO_ERR_EN adds sticky checks.
module tb_uart_fifo_buffer;

   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       wr_en, rd_en, err_clear;
   logic [7:0] wr_data;

   logic [7:0] o_rd_data   [2];
   logic       o_rd_valid  [2];
   logic [4:0] o_level     [2];
   logic       o_full      [2];
   logic       o_empty     [2];
   logic       o_af        [2];
   logic       o_ae        [2];
   logic       o_ovf       [2];
   logic       o_udf       [2];
`ifdef UART_FIFO_ERR_EN
   logic       o_ovf_sty   [2];
   logic       o_udf_sty   [2];
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   uart_fifo_buffer #(.OVERWRITE(0)) dut_drop (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]), .level(o_level[0]),
      .full(o_full[0]), .empty(o_empty[0]), .almost_full(o_af[0]), .almost_empty(o_ae[0]),
      .overflow(o_ovf[0]), .underflow(o_udf[0])
`ifdef UART_FIFO_ERR_EN
      , .err_clear(err_clear), .overflow_sticky(o_ovf_sty[0]), .underflow_sticky(o_udf_sty[0])
`endif
   );

   uart_fifo_buffer #(.OVERWRITE(1)) dut_ovw (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]), .level(o_level[1]),
      .full(o_full[1]), .empty(o_empty[1]), .almost_full(o_af[1]), .almost_empty(o_ae[1]),
      .overflow(o_ovf[1]), .underflow(o_udf[1])
`ifdef UART_FIFO_ERR_EN
      , .err_clear(err_clear), .overflow_sticky(o_ovf_sty[1]), .underflow_sticky(o_udf_sty[1])
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a queue of stored words per policy plus the expected registered outputs.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] e_data [2] = '{8'h00, 8'h00};
   logic       e_vld  [2] = '{1'b0, 1'b0};
   logic       e_ovf  [2] = '{1'b0, 1'b0};
   logic       e_udf  [2] = '{1'b0, 1'b0};
   logic       e_osty [2] = '{1'b0, 1'b0};
   logic       e_usty [2] = '{1'b0, 1'b0};

   task automatic update_sticky(input int i);
      if (e_ovf[i]) e_osty[i] = 1'b1;
      else if (err_clear) e_osty[i] = 1'b0;
      if (e_udf[i]) e_usty[i] = 1'b1;
      else if (err_clear) e_usty[i] = 1'b0;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         q0.delete();
         q1.delete();
         for (int i = 0; i < 2; i++) begin
            e_data[i] = 8'h00; e_vld[i] = 1'b0; e_ovf[i] = 1'b0; e_udf[i] = 1'b0;
            e_osty[i] = 1'b0; e_usty[i] = 1'b0;
         end
      end else begin
         // drop policy
         e_vld[0] = rd_en && (q0.size() > 0);
         e_ovf[0] = wr_en && (q0.size() == DEPTH) && !e_vld[0];
         e_udf[0] = rd_en && (q0.size() == 0);
         if (e_vld[0]) e_data[0] = q0.pop_front();
         if (wr_en && q0.size() < DEPTH) q0.push_back(wr_data);
         update_sticky(0);
         // overwrite policy
         e_vld[1] = rd_en && (q1.size() > 0);
         e_ovf[1] = wr_en && (q1.size() == DEPTH) && !e_vld[1];
         e_udf[1] = rd_en && (q1.size() == 0);
         if (e_vld[1]) e_data[1] = q1.pop_front();
         if (wr_en) begin
            if (q1.size() == DEPTH) void'(q1.pop_front());
            q1.push_back(wr_data);
         end
         update_sticky(1);
      end
   end

   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         int sz;
         sz = (i == 0) ? q0.size() : q1.size();
         chk($sformatf("rd_valid[%0d]", i), 32'(o_rd_valid[i]), 32'(e_vld[i]));
         chk($sformatf("rd_data[%0d]", i), 32'(o_rd_data[i]), 32'(e_data[i]));
         chk($sformatf("level[%0d]", i), 32'(o_level[i]), 32'(sz));
         chk($sformatf("full[%0d]", i), 32'(o_full[i]), 32'(sz == DEPTH));
         chk($sformatf("empty[%0d]", i), 32'(o_empty[i]), 32'(sz == 0));
         chk($sformatf("almost_full[%0d]", i), 32'(o_af[i]), 32'(sz >= AF));
         chk($sformatf("almost_empty[%0d]", i), 32'(o_ae[i]), 32'(sz <= AE));
         chk($sformatf("overflow[%0d]", i), 32'(o_ovf[i]), 32'(e_ovf[i]));
         chk($sformatf("underflow[%0d]", i), 32'(o_udf[i]), 32'(e_udf[i]));
`ifdef UART_FIFO_ERR_EN
         chk($sformatf("ovf_sticky[%0d]", i), 32'(o_ovf_sty[i]), 32'(e_osty[i]));
         chk($sformatf("udf_sticky[%0d]", i), 32'(o_udf_sty[i]), 32'(e_usty[i]));
`endif
      end
   end

   task automatic cyc(input logic w, input logic [7:0] d, input logic r);
      wr_en = w; wr_data = d; rd_en = r;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00; err_clear = 1'b0;
      repeat (2) @(negedge clock);
      chk("lit_reset_empty", 32'(o_empty[0]), 32'd1);
      chk("lit_reset_level", 32'(o_level[0]), 32'd0);
      chk("lit_reset_ae", 32'(o_ae[0]), 32'd1);
      chk("lit_reset_full", 32'(o_full[0]), 32'd0);
      chk("lit_reset_rd_data", 32'(o_rd_data[1]), 32'd0);
      reset = 1'b0;
      cyc(0, 8'h00, 0);

      // three writes, three reads
      cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
      chk("lit_level3", 32'(o_level[0]), 32'd3);
      cyc(0, 8'h00, 1);
      chk("lit_rd_11", 32'(o_rd_data[0]), 32'h11);
      chk("lit_vld_11", 32'(o_rd_valid[0]), 32'd1);
      cyc(0, 8'h00, 1);
      chk("lit_rd_22", 32'(o_rd_data[0]), 32'h22);
      cyc(0, 8'h00, 1);
      chk("lit_rd_33", 32'(o_rd_data[0]), 32'h33);
      chk("lit_empty_end", 32'(o_empty[0]), 32'd1);
      cyc(0, 8'h00, 0);

      // write 0..17: drop keeps 0..15, overwrite keeps 2..17
      for (int i = 0; i < 18; i++) begin
         cyc(1, 8'(i), 0);
         if (i == 15) chk("lit_full16", 32'(o_full[0]), 32'd1);
         if (i == 16) chk("lit_ovf_drop", 32'(o_ovf[0]), 32'd1);
         if (i == 17) begin
            chk("lit_ovf_ovw2", 32'(o_ovf[1]), 32'd1);
            chk("lit_level_ovw", 32'(o_level[1]), 32'd16);
         end
      end
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1);
         if (i == 0) begin
            chk("lit_first_drop", 32'(o_rd_data[0]), 32'd0);
            chk("lit_first_ovw", 32'(o_rd_data[1]), 32'd2);
         end
         if (i == 15) begin
            chk("lit_last_drop", 32'(o_rd_data[0]), 32'd15);
            chk("lit_last_ovw", 32'(o_rd_data[1]), 32'd17);
         end
      end
      cyc(0, 8'h00, 0);

      // full with simultaneous write and read
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h30 + i), 0);
      cyc(1, 8'hAA, 1);
      chk("lit_full_wr_rd_level", 32'(o_level[0]), 32'd16);
      chk("lit_full_wr_rd_noovf", 32'(o_ovf[0]), 32'd0);
      chk("lit_full_wr_rd_data", 32'(o_rd_data[0]), 32'h30);
      for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
      chk("lit_last_aa_drop", 32'(o_rd_data[0]), 32'hAA);
      chk("lit_last_aa_ovw", 32'(o_rd_data[1]), 32'hAA);

      // empty cases
      cyc(0, 8'h00, 1);
      chk("lit_udf", 32'(o_udf[0]), 32'd1);
      chk("lit_udf_novld", 32'(o_rd_valid[0]), 32'd0);
      cyc(1, 8'h55, 1);
      chk("lit_empty_wr_rd_level", 32'(o_level[0]), 32'd1);
      chk("lit_empty_wr_rd_udf", 32'(o_udf[0]), 32'd1);
      cyc(0, 8'h00, 1);
      chk("lit_rd_55", 32'(o_rd_data[0]), 32'h55);
      cyc(0, 8'h00, 0);

`ifdef UART_FIFO_ERR_EN
      for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0);
      cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
      chk("lit_ovf_sticky_held", 32'(o_ovf_sty[0]), 32'd1);
      err_clear = 1'b1;
      cyc(0, 8'h00, 0);
      err_clear = 1'b0;
      chk("lit_ovf_sticky_clr", 32'(o_ovf_sty[0]), 32'd0);
      for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
`endif

      // randomized traffic in phases with different fill/drain bias
      for (int ph = 0; ph < 6; ph++) begin
         int wp, rp;
         wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 50;
         rp = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 80 : 50;
         for (int c = 0; c < 500; c++) begin
            err_clear = ($urandom_range(0, 15) == 0);
            cyc(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp));
         end
      end
      err_clear = 1'b0;

      // asynchronous reset in the middle of traffic
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0);
      wr_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("lit_async_level", 32'(o_level[0]), 32'd0);
      chk("lit_async_empty", 32'(o_empty[0]), 32'd1);
`ifdef UART_FIFO_ERR_EN
      chk("lit_async_osty", 32'(o_ovf_sty[1]), 32'd0);
      chk("lit_async_usty", 32'(o_udf_sty[1]), 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      cyc(1, 8'h77, 0);
      cyc(0, 8'h00, 1);
      chk("lit_after_reset_rd", 32'(o_rd_data[0]), 32'h77);
      cyc(0, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_fifo_buffer.md
# uart_fifo_buffer

Parametrised synchronous FIFO for the UART datapath, placed between the UART receiver/transmitter and the debug/pipeline logic. It generalises the existing 8-bit UART FIFO. Data width and depth are configurable, and it adds:
- a selectable overflow policy (drop or overwrite-oldest),
- occupancy level output,
- programmable almost-full/almost-empty thresholds,
- a valid-qualified registered read port.

Error flags can optionally be compiled in.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_BITS, 4, log2 of depth; DEPTH = 2**ADDR_BITS.
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.
- OVERWRITE, 0, 0 = drop writes when full; 1 = overwrite oldest entry when full.

Ports:
- clock  in  1  clock; all state on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_WIDTH  word popped by last accepted read, registered.
- rd_valid  out  1  one-cycle pulse, rd_data updated this cycle.
- level  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- overflow  out  1  one-cycle pulse: write while full, with no simultaneous accepted read.
- underflow  out  1  one-cycle pulse: read while empty.

## Operation
- State: wr_ptr, rd_ptr (ADDR_BITS, natural wrap modulo DEPTH), level register (ADDR_BITS+1). Flags are combinational from level only.
- Reset values: pointers 0, level 0, rd_data 0, rd_valid 0, overflow 0, underflow 0. Therefore empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Read accepted iff rd_en && !empty. On acceptance:
  - rd_data <= mem[rd_ptr], rd_valid <= 1, rd_ptr++.
  - Otherwise rd_data holds and rd_valid <= 0.
- Write accepted iff wr_en && (!full || accepted read || OVERWRITE). On acceptance: mem[wr_ptr] <= wr_data, wr_ptr++.
- Full, wr_en, no read:
  - OVERWRITE=0: write dropped, overflow pulse, state unchanged.
  - OVERWRITE=1: write stored, rd_ptr++ (oldest lost), level stays DEPTH, overflow pulse.
- Full, wr_en && rd_en: both accepted, level unchanged, no overflow.
- Empty, wr_en && rd_en: write accepted, read rejected (no bypass), underflow pulse, level becomes 1.
- Empty, rd_en only: underflow pulse, rd_valid 0, rd_data holds.
- Level update: +1 on write-only, -1 on read-only, unchanged on both or neither. Overwrite case is unchanged.
- Storage has no reset; contents after reset are don't-care and never read before being written.

## Timing
- Write-to-empty-deassert latency: 1 cycle (level registers on the write edge).
- Read latency: rd_data/rd_valid valid the cycle after the rd_en edge.
- A word written at edge N is readable by an rd_en sampled at edge N+1.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). Pending data is discarded.

## Configuration
- Macro UART_FIFO_ERR_EN.
- Defined: adds ports overflow_sticky (out, 1), underflow_sticky (out, 1) and err_clear (in, 1).
  - Each sticky flag sets on its pulse and clears on err_clear.
  - If set and clear coincide, set wins.
  - Reset value 0.
- Undefined: these ports and registers do not exist. Pulse outputs are unaffected.

## Structure
- Package uart_fifo_pkg holds:
  - default DATA_WIDTH/ADDR_BITS constants,
  - the overflow-policy constants (POLICY_DROP = 0, POLICY_OVERWRITE = 1),
  - a level-width helper function.
- Sub-module uart_fifo_mem: simple dual-port array, one write port and one synchronous read port, no reset. The top holds pointers, level, flags and error logic.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles, then read 3 -> rd_data 0x11/0x22/0x33 each with rd_valid, level 3→0, empty = 1 at end.
- DEPTH = 16, OVERWRITE = 0: write 17 words 0..16 -> full at 16, overflow pulse on the 17th; reads return 0..15.
- OVERWRITE = 1: write 0..17 -> two overflow pulses, level 16, reads return 2..17.
- Full, simultaneous wr_en = rd_en = 1 with 0xAA -> level stays 16, no overflow, 0xAA is the last word read out.
- Empty, rd_en only -> underflow pulse, rd_valid 0. Empty, wr_en = rd_en with 0x55 -> level 1, underflow pulse, next read returns 0x55.
- With UART_FIFO_ERR_EN: force overflow, overflow_sticky = 1 until err_clear. Assert reset after 5 writes -> level 0, empty = 1, stickies 0.
